tap_mem_bank: RTL and testbench
===============================

# tap_mem_bank

Parametrised tap-weight memory bank for the neural stage datapath. It holds `LANES` independent memory lanes, each `DATA_W` bits wide and `2**ADDR_W` words deep. It supports full-row writes, single-lane (sub-word) writes, linear reads, and rotated "interleave" reads driven by internal counters. It is the generalised successor of the fixed 6×32×16 stage tap memory: lane count, width and depth are parameters, read data is registered with a valid strobe, collisions forward write data, and the interleave counters wrap cleanly at memory depth.

## Interface
Parameters:
- `LANES`, 6, number of memory lanes (≥2)
- `DATA_W`, 32, bits per lane word
- `ADDR_W`, 4, address width; depth = `2**ADDR_W`
- `LANE_W`, `$clog2(LANES)`, width of `sub_addr` (derived)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` input 1: the single clock
  - `reset` input 1: asynchronous, active-low reset
- Write side:
  - `wr_vld` input 1: full-row write strobe
  - `wr_address` input `ADDR_W`: write address for all lanes
  - `wr_data` input `LANES*DATA_W`: row data; lane k uses bits `[k*DATA_W +: DATA_W]`
  - `sub_vld` input 1: single-lane write strobe
  - `sub_addr` input `LANE_W`: target lane for a sub write
  - `sub_data` input `DATA_W`: sub-write data
- Read side:
  - `rd_vld` input 1: read strobe
  - `rd_address` input `ADDR_W`: linear read address
  - `inter` input 1: interleave read mode / counter advance
  - `inter_first` input 1: restart the interleave sequence
  - `rd_data` output `LANES*DATA_W`: registered read row
  - `rd_data_vld` output 1: `rd_data` is valid this cycle

## Operation
- **Storage:** per-lane arrays are internal and are not reset. Content is X until written or preloaded via `$readmemh` in the bench.
- **Writes (evaluated on the rising edge of `clk`):**
  - `sub_vld=1`: write only lane `sub_addr` at `wr_address` with `sub_data`. All other lanes are untouched and `wr_vld` is ignored.
  - `sub_vld=1` with `sub_addr ≥ LANES`: no lane is written.
  - `sub_vld=0` and `wr_vld=1`: write every lane at `wr_address` with its slice of `wr_data`.
- **Interleave counters:**
  - `cnt0` is in [0, LANES-1]. `cnt1` is `ADDR_W` bits wide.
  - `cnt0` update, only while `inter=1`:
    - `inter_first=1` → `cnt0=0`
    - else if `cnt0==LANES-1` → `cnt0=0`
    - else `cnt0+1`
  - `cnt1` update, only while `inter=1`:
    - `inter_first=1` → `cnt1=0`
    - else if `cnt0==LANES-1` → `cnt1 = (cnt1+LANES) mod 2**ADDR_W`
    - `cnt1` never advances when `inter=0`.
- **Read address for lane k:**
  - When `inter & ~inter_first`: `((cnt0+k) mod LANES) + cnt1`, truncated to `ADDR_W` bits. The mod is computed as a single conditional subtract of LANES.
  - Otherwise: `rd_address`.
  - Counter values are those before the edge, i.e. current register values.
- **Read data:**
  - On `rd_vld=1`, each lane's word at its read address is registered into `rd_data`, and `rd_data_vld` is set for one cycle.
  - On `rd_vld=0`, `rd_data` holds its previous value and `rd_data_vld=0`.
- **Collision:** if a lane is written and read at the same address in the same cycle, that lane's `rd_data` slice returns the new write data (write-first forwarding), per lane.
- **Reset:** mid-operation reset immediately clears the counters and outputs. Memory contents are preserved.

## Timing
- Reset values: `rd_data=0`, `rd_data_vld=0`, `cnt0=0`, `cnt1=0`.
- Read latency is 1 cycle: `rd_vld` sampled at edge N produces `rd_data`/`rd_data_vld` valid after edge N.
- Write latency is 1 cycle: a write at edge N is visible to reads issued from edge N onward (via forwarding).
- Back-to-back reads are supported every cycle. There is no backpressure and no stall input.
- `inter_first` in the same cycle as `inter`: the read uses `rd_address` and the counters clear at that edge.
- The first interleave read occurs on the next cycle with `cnt0=0`, `cnt1=0`.
- `cnt1` wrap example (ADDR_W=4, LANES=6): 12 → 2, since 18 mod 16 = 2. Wrap is silent, with no flag.

## Test plan
All scenarios use LANES=6, DATA_W=32, ADDR_W=4.
- **Reset:** drive `reset=0` asynchronously mid-read → `rd_data=0` and `rd_data_vld=0` immediately, counters 0. After release, preloaded memory still reads back intact.
- **Row write / linear read:** write row `{k*0x1000+a}` to every address a, then read address 5 → lane k returns `k*0x1000+5` one cycle later, with `rd_data_vld` high for exactly that cycle.
- **Sub write:** `sub_vld=1`, `sub_addr=3`, `wr_address=7`, `sub_data=0xDEADBEEF`, `wr_vld=1` → only lane 3 word 7 changes. `sub_addr=6` → no lane changes.
- **Interleave rotation:** one `inter_first`, then continuous `inter` and `rd_vld`. On the 3rd interleave read (cnt0=2, cnt1=0), lane 0 reads address 2 and lane 5 reads address 1. On the 7th (cnt0=0, cnt1=6), lane 0 reads address 6 and lane 4 reads address 10.
- **Wrap:** 18 consecutive interleave cycles bring `cnt1` to 2 (12+6 mod 16). Lane 0 then reads address 2 and lane 5 reads address 7.
- **Collision:** write 0x55 to lane 1 address 4 while reading address 4 → `rd_data` lane 1 = 0x55, and the other lanes return their old contents.

Source files
------------

// File: rtl/tap_mem_bank.sv
// Tap-weight memory bank: LANES independent lanes with row and sub-word writes.
// Linear or counter-driven rotated reads, registered with a valid strobe.
module tap_mem_bank #(
    parameter int LANES  = 6,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_vld,
    input  logic [ADDR_W-1:0]       wr_address,
    input  logic [LANES*DATA_W-1:0] wr_data,
    input  logic                    sub_vld,
    input  logic [LANE_W-1:0]       sub_addr,
    input  logic [DATA_W-1:0]       sub_data,
    input  logic                    rd_vld,
    input  logic [ADDR_W-1:0]       rd_address,
    input  logic                    inter,
    input  logic                    inter_first,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    rd_data_vld
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int EXT_W = ((ADDR_W > LANE_W) ? ADDR_W : LANE_W) + 2;
    localparam logic [LANE_W-1:0] LAST = LANE_W'(LANES - 1);

    logic [LANE_W-1:0]       r_cnt0;
    logic [ADDR_W-1:0]       r_cnt1;
    logic [LANES*DATA_W-1:0] r_rd_data;
    logic                    r_rd_vld;
    logic [LANES*DATA_W-1:0] w_rd_next;
    logic                    w_rot;

    // Rotated addressing only once the sequence has been restarted.
    assign w_rot = inter & ~inter_first;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic              w_we;
        logic [DATA_W-1:0] w_wdata;
        logic [EXT_W-1:0]  w_sum;
        logic [EXT_W-1:0]  w_mod;
        logic [ADDR_W-1:0] w_raddr;

        // A sub write owns the cycle; out-of-range lanes match nothing.
        assign w_we    = sub_vld ? (sub_addr == LANE_W'(k)) : wr_vld;
        assign w_wdata = sub_vld ? sub_data : wr_data[k*DATA_W +: DATA_W];

        // Lane rotation with a single conditional subtract.
        assign w_sum   = EXT_W'(r_cnt0) + EXT_W'(k);
        assign w_mod   = (w_sum >= EXT_W'(LANES)) ? (w_sum - EXT_W'(LANES))
                                                  : w_sum;
        assign w_raddr = w_rot ? ADDR_W'(w_mod + EXT_W'(r_cnt1))
                               : rd_address;

        // Write-first forwarding on a same-address collision.
        assign w_rd_next[k*DATA_W +: DATA_W] =
            (w_we && (wr_address == w_raddr)) ? w_wdata : r_mem[w_raddr];

        // Lane storage, deliberately not reset.
        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[wr_address] <= w_wdata;
            end
        end
    end

    // Interleave counters advance only while inter is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (inter) begin
            if (inter_first) begin
                r_cnt0 <= '0;
                r_cnt1 <= '0;
            end else if (r_cnt0 == LAST) begin
                r_cnt0 <= '0;
                r_cnt1 <= r_cnt1 + ADDR_W'(LANES);
            end else begin
                r_cnt0 <= r_cnt0 + LANE_W'(1);
            end
        end
    end

    // Registered read row; holds its value when no read is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= rd_vld;
            if (rd_vld) begin
                r_rd_data <= w_rd_next;
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_data_vld = r_rd_vld;

endmodule

// File: tb/tb_tap_mem_bank.sv
// Bench for tap_mem_bank: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_tap_mem_bank;

    localparam int L = 6;
    localparam int D = 32;
    localparam int A = 4;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_vld;
    logic [A-1:0]   wr_address;
    logic [L*D-1:0] wr_data;
    logic           sub_vld;
    logic [2:0]     sub_addr;
    logic [D-1:0]   sub_data;
    logic           rd_vld;
    logic [A-1:0]   rd_address;
    logic           inter;
    logic           inter_first;
    logic [L*D-1:0] rd_data;
    logic           rd_data_vld;

    logic [D-1:0]   mem [L][N];
    int             c0;
    int             c1;
    logic [L*D-1:0] exp_rd;
    logic           exp_vld;
    int             vectors = 0;
    int             errors  = 0;

    tap_mem_bank #(.LANES(L), .DATA_W(D), .ADDR_W(A)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_vld      (wr_vld),
        .wr_address  (wr_address),
        .wr_data     (wr_data),
        .sub_vld     (sub_vld),
        .sub_addr    (sub_addr),
        .sub_data    (sub_data),
        .rd_vld      (rd_vld),
        .rd_address  (rd_address),
        .inter       (inter),
        .inter_first (inter_first),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [L*D-1:0] obs,
                       input logic [L*D-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        wr_vld = 0; sub_vld = 0; rd_vld = 0;
        inter = 0; inter_first = 0;
        wr_address = '0; wr_data = '0; sub_addr = '0;
        sub_data = '0; rd_address = '0;
    endtask

    // Apply one clock edge to the model and the DUT, then compare.
    task automatic step(input string tag);
        logic         we [L];
        logic [D-1:0] wd [L];
        int           ra;
        for (int k = 0; k < L; k++) begin
            we[k] = sub_vld ? (int'(sub_addr) == k) : wr_vld;
            wd[k] = sub_vld ? sub_data : wr_data[k*D +: D];
        end
        if (rd_vld) begin
            for (int k = 0; k < L; k++) begin
                if (inter && !inter_first)
                    ra = (((c0 + k) % L) + c1) % N;
                else
                    ra = int'(rd_address);
                exp_rd[k*D +: D] = (we[k] && int'(wr_address) == ra)
                                   ? wd[k] : mem[k][ra];
            end
        end
        exp_vld = rd_vld;
        for (int k = 0; k < L; k++)
            if (we[k]) mem[k][wr_address] = wd[k];
        if (inter) begin
            if (inter_first) begin
                c0 = 0; c1 = 0;
            end else if (c0 == L - 1) begin
                c0 = 0; c1 = (c1 + L) % N;
            end else begin
                c0 = c0 + 1;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_data"}, rd_data, exp_rd);
        chk({tag, "_vld"}, {{(L*D-1){1'b0}}, rd_data_vld},
            {{(L*D-1){1'b0}}, exp_vld});
    endtask

    task automatic lane_chk(input string tag, input int k, input logic [D-1:0] v);
        chk(tag, {{(L*D-D){1'b0}}, rd_data[k*D +: D]}, {{(L*D-D){1'b0}}, v});
    endtask

    initial begin
        idle();
        reset = 0;
        c0 = 0; c1 = 0; exp_rd = '0; exp_vld = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data", rd_data, '0);
        chk("reset_vld", {{(L*D-1){1'b0}}, rd_data_vld}, '0);
        @(negedge clk);
        reset = 1;

        // Fill every row with k*0x1000+a.
        for (int a = 0; a < N; a++) begin
            wr_vld = 1; wr_address = A'(a);
            for (int k = 0; k < L; k++)
                wr_data[k*D +: D] = 32'(k * 32'h1000 + a);
            step("fill");
        end
        idle();

        // Linear read of address 5, valid for one cycle only.
        rd_vld = 1; rd_address = 4'd5;
        step("lin5");
        for (int k = 0; k < L; k++)
            lane_chk("lin5_lane", k, 32'(k * 32'h1000 + 5));
        idle();
        step("lin5_after");

        // Sub write to lane 3 wins over a simultaneous row write.
        sub_vld = 1; sub_addr = 3'd3; wr_address = 4'd7;
        sub_data = 32'hDEADBEEF; wr_vld = 1;
        wr_data = {6{32'hA5A5A5A5}};
        step("sub3");
        idle();
        rd_vld = 1; rd_address = 4'd7;
        step("sub3_rd");
        lane_chk("sub3_l3", 3, 32'hDEADBEEF);
        lane_chk("sub3_l2", 2, 32'h2007);
        idle();

        // Out-of-range lane writes nothing.
        sub_vld = 1; sub_addr = 3'd6; wr_address = 4'd8;
        sub_data = 32'h12345678; wr_vld = 1;
        step("sub6");
        idle();
        rd_vld = 1; rd_address = 4'd8;
        step("sub6_rd");
        for (int k = 0; k < L; k++)
            lane_chk("sub6_lane", k, 32'(k * 32'h1000 + 8));
        idle();

        // Interleave: restart, then 19 rotated reads.
        inter = 1; inter_first = 1; rd_vld = 1; rd_address = 4'd9;
        step("ifirst");
        lane_chk("ifirst_l0", 0, 32'h0009);
        inter_first = 0;
        for (int n = 1; n <= 19; n++) begin
            step("inter");
            if (n == 3) begin
                lane_chk("rot3_l0", 0, 32'h0002);
                lane_chk("rot3_l5", 5, 32'h5001);
            end
            if (n == 7) begin
                lane_chk("rot7_l0", 0, 32'h0006);
                lane_chk("rot7_l4", 4, 32'h400A);
            end
            if (n == 19) begin
                lane_chk("wrap_l0", 0, 32'h0002);
                lane_chk("wrap_l5", 5, 32'h5007);
            end
        end
        idle();

        // Collision forwards the new word on lane 1 only.
        sub_vld = 1; sub_addr = 3'd1; wr_address = 4'd4;
        sub_data = 32'h55; rd_vld = 1; rd_address = 4'd4;
        step("coll");
        for (int k = 0; k < L; k++)
            lane_chk("coll_lane", k, (k == 1) ? 32'h55 : 32'(k * 32'h1000 + 4));
        idle();

        // Asynchronous reset in the middle of a read cycle.
        rd_vld = 1; rd_address = 4'd3;
        step("pre_rst");
        #2;
        reset = 0;
        #1;
        chk("async_rst_data", rd_data, '0);
        chk("async_rst_vld", {{(L*D-1){1'b0}}, rd_data_vld}, '0);
        exp_rd = '0; c0 = 0; c1 = 0;
        @(negedge clk);
        reset = 1;
        idle();
        rd_vld = 1; rd_address = 4'd3;
        step("post_rst");
        lane_chk("post_rst_l5", 5, 32'h5003);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr_vld      = ($urandom_range(0, 3) == 0);
            sub_vld     = ($urandom_range(0, 4) == 0);
            sub_addr    = 3'($urandom_range(0, 7));
            sub_data    = $urandom;
            wr_address  = 4'($urandom_range(0, N - 1));
            for (int k = 0; k < L; k++) wr_data[k*D +: D] = $urandom;
            rd_vld      = ($urandom_range(0, 9) < 7);
            rd_address  = 4'($urandom_range(0, N - 1));
            inter       = ($urandom_range(0, 1) == 1);
            inter_first = ($urandom_range(0, 15) == 0);
            step("rand");
        end
        idle();
        step("tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
